// File: rtl/tristate_bus_arbiter_pkg.sv
// Purpose : shared types and helpers for the tri-state bus arbiter.
// Latency : none (declarations only).
// Backpressure: n/a.
// Contents: arbiter state enum, turnaround counter width, one-hot encoder.
package tsb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int TURN_W = 4;
  localparam int MAX_CH = 32;

  // One-hot of a channel index; callers truncate to their channel count.
  function automatic logic [MAX_CH-1:0] onehot(input logic [4:0] idx);
    return MAX_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Purpose : combinational round-robin finder (first set req bit at/after ptr).
// Latency : combinational, zero cycles.
// Backpressure: n/a; pure function of req and ptr.
// Ports   : req[NCH] requests, ptr start index -> winner index, any = |req.
module rr_pick #(
  parameter int NCH = 4,
  parameter int PW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [PW-1:0]  winner,
  output logic           any
);

  logic [PW-1:0] idx;

  // Scan from the farthest candidate back to ptr so the nearest set bit
  // is the last one written and therefore wins.
  always_comb begin
    winner = ptr;
    idx    = '0;
    any    = |req;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NCH);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Purpose : round-robin owner of a shared tri-state bus with bounded bursts
//           and a guaranteed high-Z turnaround gap between owners.
// Latency : req sampled in IDLE at edge k -> gnt in cycle k+1; a transfer at
//           edge e drives the bus in cycle e+1.
// Backpressure: a channel holds the bus while req stays high, up to MAXBURST
//           beats; dropping req releases the bus at that edge with no beat.
// Ports   : clk, rst (async, active-high), req[NCH], din[NCH*WIDTH],
//           gnt[NCH] one-hot, owner index, bus (inout), bus_valid (= oe).
module tristate_bus_arbiter
  import tsb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int MAXBURST = 4,
  parameter int TURN     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*WIDTH-1:0]     din,
  output logic [NCH-1:0]           gnt,
  output logic [$clog2(NCH)-1:0]   owner,
  inout  wire  [WIDTH-1:0]         bus,
  output logic                     bus_valid
);

  localparam int PW = $clog2(NCH);
  localparam int BW = $clog2(MAXBURST + 1);

  state_t             state_q, state_d;
  logic [NCH-1:0]     gnt_q, gnt_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [BW-1:0]      beats_q, beats_d;
  logic [TURN_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]   dq_q, dq_d;
  logic               oe_q, oe_d;

  logic [PW-1:0]      pick_w;
  logic               pick_any;
  logic               xfer;
  logic [WIDTH-1:0]   din_arr [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_din
    assign din_arr[i] = din[i*WIDTH +: WIDTH];
  end

  rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_w),
    .any    (pick_any)
  );

  // gnt is only non-zero in DRIVE, so this is the per-edge beat strobe.
  assign xfer = req[owner_q] & gnt_q[owner_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    oe_d    = xfer;
    dq_d    = xfer ? din_arr[owner_q] : dq_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d = pick_w;
          gnt_d   = NCH'(onehot(5'(pick_w)));
          beats_d = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (xfer) beats_d = beats_q + 1'b1;
        // Release on a dropped request, or on the beat that fills the burst.
        if (!xfer || beats_q == BW'(MAXBURST - 1)) begin
          gnt_d = '0;
          ptr_d = (owner_q == PW'(NCH - 1)) ? '0 : owner_q + 1'b1;
          if (TURN > 0) begin
            state_d = ST_TURN;
            cnt_d   = TURN_W'(TURN - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign bus_valid = oe_q;

  // Sole driver of the shared bus; oe_q clears asynchronously on rst.
  assign bus = oe_q ? dq_q : 'z;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
module tb_tristate_bus_arbiter;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int MAXB  = 4;
  localparam int TURN  = 2;

  logic                 clk = 1'b0;
  logic                 rst, rst0;
  logic [NCH-1:0]       req, req0;
  logic [NCH*WIDTH-1:0] din, din0;
  logic [NCH-1:0]       gnt, gnt0;
  logic [1:0]           owner, owner0;
  wire  [WIDTH-1:0]     bus, bus0;
  logic                 bus_valid, bus_valid0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: grant flag, owner, beats taken, rotation start,
  // first edge at which arbitration may occur again, running edge count.
  bit         m_gr;
  int         m_own, m_beats, m_ptr, m_next, m_edge;
  bit         e_valid;
  logic [7:0] e_dq;
  logic [3:0] e_gnt;

  tristate_bus_arbiter #(.WIDTH(WIDTH), .NCH(NCH), .MAXBURST(MAXB), .TURN(TURN)) u_dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .owner(owner),
    .bus(bus), .bus_valid(bus_valid)
  );

  tristate_bus_arbiter #(.WIDTH(WIDTH), .NCH(NCH), .MAXBURST(MAXB), .TURN(0)) u_dut0 (
    .clk(clk), .rst(rst0), .req(req0), .din(din0), .gnt(gnt0), .owner(owner0),
    .bus(bus0), .bus_valid(bus_valid0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_gr = 0; m_own = 0; m_beats = 0; m_ptr = 0; m_next = m_edge;
    e_valid = 0; e_dq = '0; e_gnt = '0;
  endtask

  // Advance the model across one rising edge using the current req/din.
  task automatic model_edge();
    e_valid = 0;
    if (m_gr) begin
      if (req[m_own]) begin
        e_valid = 1;
        e_dq    = din[m_own*WIDTH +: WIDTH];
        m_beats++;
      end
      if (!req[m_own] || m_beats == MAXB) begin
        m_gr   = 0;
        m_ptr  = (m_own + 1) % NCH;
        m_next = m_edge + TURN + 1;
      end
    end else if (m_edge >= m_next && req != 0) begin
      for (int k = 0; k < NCH; k++) begin
        if (req[(m_ptr + k) % NCH]) begin
          m_own = (m_ptr + k) % NCH;
          break;
        end
      end
      m_gr = 1; m_beats = 0;
    end
    e_gnt = m_gr ? 4'(1 << m_own) : 4'b0;
    m_edge++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; rst0 = 1;
    @(negedge clk);
    rst = 0; rst0 = 0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1; rst0 = 1; req = 4'b1111; din = '0; req0 = '0; din0 = '0;
    m_edge = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (gnt !== 4'b0 || bus_valid !== 1'b0 || owner !== 2'd0) begin
        n_err++;
        $display("FAIL reset c%0d: gnt=%b valid=%b owner=%0d, expected gnt=0000 valid=0 owner=0", c, gnt, bus_valid, owner);
      end
    end
    req = '0;
    rst = 0; rst0 = 0;
    model_reset();
  endtask

  task automatic test_single_burst();
    int zrun, first_run, gap;
    bit seen;
    req = 4'b0010; din = '0; din[15:8] = 8'hA5;
    zrun = 0; first_run = 0; gap = -1; seen = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); model_edge(); @(negedge clk);
      n_vec++;
      if (bus_valid !== e_valid || gnt !== e_gnt || owner !== 2'(m_own) || (e_valid && bus !== e_dq)) begin
        n_err++;
        $display("FAIL single c%0d: valid=%b gnt=%b owner=%0d bus=%h, expected valid=%b gnt=%b owner=%0d bus=%h", c, bus_valid, gnt, owner, bus, e_valid, e_gnt, m_own, e_dq);
      end
      if (bus_valid) begin
        if (seen && zrun > 0 && gap < 0) gap = zrun;
        if (gap < 0) first_run++;
        seen = 1; zrun = 0;
      end else begin
        zrun++;
      end
    end
    n_vec++;
    if (first_run !== MAXB || gap !== TURN + 1) begin
      n_err++;
      $display("FAIL single_shape: burst=%0d gap=%0d, expected burst=%0d gap=%0d", first_run, gap, MAXB, TURN + 1);
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int owners[$];
    int exp_own[5] = '{0, 1, 2, 3, 0};
    int vlen, zlen;
    bit prev, seen;
    do_reset();
    req = 4'b1111;
    vlen = 0; zlen = 0; prev = 0; seen = 0;
    for (int c = 0; c < 40; c++) begin
      din = {$urandom()};
      @(posedge clk); model_edge(); @(negedge clk);
      n_vec++;
      if (bus_valid !== e_valid || gnt !== e_gnt || owner !== 2'(m_own) || (e_valid && bus !== e_dq)) begin
        n_err++;
        $display("FAIL rr c%0d: valid=%b gnt=%b owner=%0d bus=%h, expected valid=%b gnt=%b owner=%0d bus=%h", c, bus_valid, gnt, owner, bus, e_valid, e_gnt, m_own, e_dq);
      end
      if (gnt != 0 && !prev) owners.push_back(int'(owner));
      prev = (gnt != 0);
      if (bus_valid) begin
        if (seen && zlen > 0) begin
          n_vec++;
          if (zlen !== TURN + 1) begin
            n_err++;
            $display("FAIL rr_gap c%0d: gap=%0d, expected %0d", c, zlen, TURN + 1);
          end
        end
        vlen++; zlen = 0; seen = 1;
      end else begin
        if (vlen > 0) begin
          n_vec++;
          if (vlen !== MAXB) begin
            n_err++;
            $display("FAIL rr_burst c%0d: beats=%0d, expected %0d", c, vlen, MAXB);
          end
        end
        vlen = 0; zlen++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= owners.size()) begin
        n_err++;
        $display("FAIL rr_order[%0d]: no grant observed, expected owner %0d", i, exp_own[i]);
      end else if (owners[i] !== exp_own[i]) begin
        n_err++;
        $display("FAIL rr_order[%0d]: owner=%0d, expected %0d", i, owners[i], exp_own[i]);
      end
    end
    req = '0;
  endtask

  task automatic test_early_release();
    int ch2_beats, next_own;
    bit prev;
    do_reset();
    din = '0; din[23:16] = 8'hC2; din[31:24] = 8'hD3;
    ch2_beats = 0; next_own = -1; prev = 0;
    for (int c = 0; c < 10; c++) begin
      req = (c < 3) ? 4'b0100 : 4'b1000;
      @(posedge clk); model_edge(); @(negedge clk);
      n_vec++;
      if (bus_valid !== e_valid || gnt !== e_gnt || owner !== 2'(m_own) || (e_valid && bus !== e_dq)) begin
        n_err++;
        $display("FAIL early c%0d: valid=%b gnt=%b owner=%0d bus=%h, expected valid=%b gnt=%b owner=%0d bus=%h", c, bus_valid, gnt, owner, bus, e_valid, e_gnt, m_own, e_dq);
      end
      if (bus_valid && bus === 8'hC2) ch2_beats++;
      if (c > 3 && gnt != 0 && !prev && next_own < 0) next_own = int'(owner);
      prev = (gnt != 0);
    end
    n_vec++;
    if (ch2_beats !== 2 || next_own !== 3) begin
      n_err++;
      $display("FAIL early_shape: ch2 beats=%0d next owner=%0d, expected beats=2 owner=3", ch2_beats, next_own);
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    req = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      din = {$urandom()};
      @(posedge clk); model_edge(); @(negedge clk);
      n_vec++;
      if (bus_valid !== e_valid || gnt !== e_gnt || owner !== 2'(m_own) || (e_valid && bus !== e_dq)) begin
        n_err++;
        $display("FAIL random c%0d: req=%b valid=%b gnt=%b owner=%0d bus=%h, expected valid=%b gnt=%b owner=%0d bus=%h", c, req, bus_valid, gnt, owner, bus, e_valid, e_gnt, m_own, e_dq);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid_burst();
    int beats, first_own;
    bit prev;
    do_reset();
    req = 4'b1000; din = '0; din[31:24] = 8'h3C;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(posedge clk); model_edge(); @(negedge clk);
      if (bus_valid) beats++;
    end
    n_vec++;
    if (beats !== 2) begin
      n_err++;
      $display("FAIL midrst_wait: beats seen=%0d, expected 2 within 20 cycles", beats);
    end
    #2 rst = 1;
    #1;
    n_vec++;
    if (bus_valid !== 1'b0 || gnt !== 4'b0 || owner !== 2'd0) begin
      n_err++;
      $display("FAIL midrst_async: valid=%b gnt=%b owner=%0d, expected valid=0 gnt=0000 owner=0", bus_valid, gnt, owner);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    req = 4'b1001;
    first_own = -1; prev = 0;
    for (int c = 0; c < 8; c++) begin
      din = {$urandom()};
      @(posedge clk); model_edge(); @(negedge clk);
      n_vec++;
      if (bus_valid !== e_valid || gnt !== e_gnt || owner !== 2'(m_own) || (e_valid && bus !== e_dq)) begin
        n_err++;
        $display("FAIL midrst c%0d: valid=%b gnt=%b owner=%0d bus=%h, expected valid=%b gnt=%b owner=%0d bus=%h", c, bus_valid, gnt, owner, bus, e_valid, e_gnt, m_own, e_dq);
      end
      if (gnt != 0 && !prev && first_own < 0) first_own = int'(owner);
      prev = (gnt != 0);
    end
    n_vec++;
    if (first_own !== 0) begin
      n_err++;
      $display("FAIL midrst_first: first owner=%0d, expected 0", first_own);
    end
    req = '0;
  endtask

  task automatic test_turn0();
    int last0, first1, run0;
    do_reset();
    req0 = 4'b0011; din0 = '0; din0[7:0] = 8'h10; din0[15:8] = 8'h21;
    last0 = -1; first1 = -1; run0 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_valid0 && bus0 === 8'h10 && first1 < 0) begin last0 = c; run0++; end
      if (bus_valid0 && bus0 === 8'h21 && first1 < 0) first1 = c;
    end
    n_vec++;
    if (first1 < 0 || last0 < 0 || first1 - last0 - 1 !== 1 || run0 !== MAXB) begin
      n_err++;
      $display("FAIL turn0_gap: ch0 beats=%0d last0=%0d first1=%0d, expected %0d beats and a 1-cycle gap", run0, last0, first1, MAXB);
    end
    req0 = '0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_early_release();
    test_random();
    test_reset_mid_burst();
    test_turn0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Parametrised owner of a shared tri-state data bus. It arbitrates NCH requesters round-robin, drives the granted channel's data onto a single inout bus through a bufif1-style enable, and bounds each ownership to MAXBURST beats. Between different bus owners it inserts a guaranteed high-Z turnaround gap of TURN+1 cycles, so two drivers never overlap. It sits between local channel sources and an external or shared wired bus.

## Interface
Parameters:
- WIDTH, default 8: bus and per-channel data width; must be ≥1.
- NCH, default 4: number of requesting channels; must be ≥2.
- MAXBURST, default 4: maximum beats per grant; must be ≥1.
- TURN, default 1: extra high-Z turnaround cycles on release; legal range 0..15.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req  input  NCH  per-channel request, one bit per channel.
- din  input  NCH*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- gnt  output  NCH  registered one-hot grant, or all zero.
- owner  output  clog2(NCH)  index of the current or last owner.
- bus  inout  WIDTH  shared bus: equals dq when oe=1, otherwise high-Z.
- bus_valid  output  1  high in every cycle the bus carries a beat; always equal to the internal oe.

## Operation
- Reset values, applied asynchronously while rst=1:
  - state = IDLE.
  - gnt = 0, owner = 0, ptr = 0, beats = 0, cnt = 0.
  - dq = 0, oe = 0, bus_valid = 0.
  - bus is high-Z immediately, with no clock edge required.
- Transfer rule: a beat transfers at an edge where req[owner]=1 and gnt[owner]=1. On that edge:
  - dq <= din[owner].
  - oe <= 1 and bus_valid <= 1.
  - beats increments.
- At any edge without a transfer, oe <= 0 and bus_valid <= 0.
- State machine, states IDLE, DRIVE, TURN:
  - IDLE, edge with any req bit set:
    - Pick the winner w = first set req bit at or after ptr, wrapping modulo NCH.
    - owner <= w, gnt <= onehot(w), beats <= 0, state <= DRIVE.
  - IDLE, edge with no req bit set: remain in IDLE.
  - DRIVE: release occurs at an edge when either condition holds:
    - req[owner]=0 (no transfer happens at that edge), or
    - the transfer at that edge is beat number MAXBURST.
  - Actions on release:
    - gnt <= 0.
    - ptr <= (owner+1) mod NCH.
    - If TURN>0: state <= TURN and cnt <= TURN−1.
    - If TURN=0: state <= IDLE.
  - TURN: cnt decrements each cycle. When cnt=0, state <= IDLE. No grants are issued during TURN.
- Requesters may deassert req at any time; only req&gnt edges capture data.
- A lone requester regains the bus after the turnaround gap.
- Width rules:
  - beats is clog2(MAXBURST+1) bits.
  - cnt is 4 bits.
  - ptr wraps from NCH−1 to 0.

## Timing
- Grant latency: req sampled in IDLE at edge k → gnt high in cycle k+1. The first possible transfer is at edge k+1, with data on the bus in cycle k+2.
- Data latency: a transfer at edge e puts data on the bus in cycle e+1.
- Back-to-back beats from the same owner drive the bus continuously, with no gap.
- Owner-change gap, measured after the last driven cycle: the bus is high-Z for exactly TURN+1 cycles before the next beat when requests are pending. It is never less than 1 cycle.
- Reset mid-burst: the bus floats asynchronously. The in-flight beat is dropped. After rst falls, arbitration restarts from ptr=0.

## Structure
- Shared package tsb_pkg contains:
  - state enum {IDLE, DRIVE, TURN}.
  - TURN_W = 4.
  - Function onehot(idx).
- Sub-module rr_pick: combinational round-robin finder. Inputs are req and ptr; outputs are winner and any. The arbiter instantiates it once.
- The tri-state driver is a single continuous assignment: bus = oe ? dq : 'z. No other driver exists.

## Test plan
- Reset: hold rst=1 with req=4'b1111 → gnt=0, bus_valid=0, bus is all Z. Assert rst asynchronously between edges → bus is Z within the same cycle.
- Single burst (MAXBURST=4, TURN=2): req[1]=1 held, din[1]=8'hA5 → gnt=4'b0010 one cycle after sampling. bus=8'hA5 for 4 consecutive cycles, then Z for exactly 3 cycles, then ch1's next burst begins.
- Round-robin: req=4'b1111 held → owners in order 0,1,2,3,0. Each owner gets 4 beats. Every owner change shows TURN+1 Z cycles.
- Early release: ch2 drops req after 2 transfers → exactly 2 beats on the bus, gnt drops at that edge, and ch3 wins next when requesting.
- TURN=0: ch0 and ch1 both requesting → exactly 1 Z cycle between ch0's last beat and ch1's first beat.
- Reset mid-burst: rst pulse during ch3's second beat → bus is Z immediately, gnt=0. After release, with req=4'b1001, ch0 is granted first (ptr=0).
